// File: rtl/soc_vga_scanout_if.sv
// soc_vga_scanout_if: framebuffer read-only byte port (address out, RGB332 data back one clk later)
interface soc_vga_scanout_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] word_addr_b;
  logic [7:0]            read_data_b;
  modport master (output word_addr_b, input read_data_b);
  modport slave  (input word_addr_b, output read_data_b);
endinterface

// File: rtl/soc_vga_scanout.sv
// soc_vga_scanout: VGA timing, doubled-pixel framebuffer addressing, RGB332 to 4:4:4 expansion, frame irq
module soc_vga_scanout #(
  parameter int ADDR_WIDTH  = 32,
  parameter int PIX_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int FB_WIDTH    = 320
) (
  input  logic                clk,
  input  logic                res,
  input  logic                enable,
  soc_vga_scanout_if.master   fb,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                frame_irq
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(PIX_DIV);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ALAST  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_MASK   = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(FB_WIDTH);

  logic [DW-1:0]         div_q, div_d;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  en_q, en_d;
  logic [11:0]           rgb_q, rgb_d;
  logic                  hs_q, hs_d, vs_q, vs_d, irq_q, irq_d;
  logic                  tick, h_end, v_end, line_adv, active;
  logic [7:0]            d;

  always_comb begin
    tick     = div_q == DIV_LAST;
    h_end    = h_q == H_LAST;
    v_end    = v_q == V_LAST;
    line_adv = tick && h_end;
    active   = (h_q < H_ACT) && (v_q < V_ACT);
    d        = fb.read_data_b;
    div_d    = tick ? '0 : div_q + 1'b1;
    h_d      = tick ? (h_end ? '0 : h_q + 1'b1) : h_q;
    v_d      = line_adv ? (v_end ? '0 : v_q + 1'b1) : v_q;
    // one framebuffer line serves 2^SCALE_SHIFT display lines
    base_d   = !line_adv ? base_q :
               v_end ? '0 :
               ((v_q & V_MASK) == V_MASK && v_q < V_ACT) ? base_q + STEP : base_q;
    // the new frame's enable already governs its first pixel
    en_d     = (tick && h_q == '0 && v_q == '0) ? enable : en_q;
    rgb_d    = !tick ? rgb_q :
               (active && en_d) ? {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]} : '0;
    hs_d     = tick ? ((h_q >= H_SS && h_q <= H_SE) ? SYNC_POL : ~SYNC_POL) : hs_q;
    vs_d     = tick ? ((v_q >= V_SS && v_q <= V_SE) ? SYNC_POL : ~SYNC_POL) : vs_q;
    irq_d    = line_adv && v_q == V_ALAST;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      base_q <= '0;
      en_q   <= 1'b0;
      rgb_q  <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      irq_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      base_q <= base_d;
      en_q   <= en_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      irq_q  <= irq_d;
    end
  end

  assign fb.word_addr_b = base_q + ADDR_WIDTH'(h_q >> SCALE_SHIFT);
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign frame_irq = irq_q;
endmodule

// File: tb/tb_soc_vga_scanout.sv
// tb_soc_vga_scanout: directed checks on a shrunken 24x12-pixel raster (frame = 1152 clk)
module tb_soc_vga_scanout;
  logic clk = 1'b0;
  logic res = 1'b0;
  logic enable = 1'b1;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, frame_irq;
  logic [7:0] mem [64];
  int cyc = 0;
  int irq_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  soc_vga_scanout_if #(.ADDR_WIDTH(32)) fbi ();

  soc_vga_scanout #(
    .ADDR_WIDTH(32), .PIX_DIV(4),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .SCALE_SHIFT(1), .FB_WIDTH(8)
  ) dut (
    .clk(clk), .res(res), .enable(enable), .fb(fbi.master),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    fbi.read_data_b <= (fbi.word_addr_b < 64) ? mem[fbi.word_addr_b[5:0]] : 8'h00;

  always @(posedge clk or negedge res)
    if (!res) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk)
    if (frame_irq) irq_cnt <= irq_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    check($sformatf("sync_cyc_%0d", n), cyc, n);
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    check(tag, {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
    mem[5] = 8'hE3;
    mem[6] = 8'h1C;
    mem[7] = 8'h96;
    repeat (10) @(posedge clk);
    #1;
    chk_rgb("rst_rgb", 12'h000);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_addr", fbi.word_addr_b, 0);
    check("rst_irq", frame_irq, 0);
    @(negedge clk);
    res = 1'b1;
    at_cyc(0);  check("addr_h0", fbi.word_addr_b, 0);
    at_cyc(4);  check("addr_h1", fbi.word_addr_b, 0);
    at_cyc(7);  check("addr_h1_end", fbi.word_addr_b, 0);
    at_cyc(8);  check("addr_h2", fbi.word_addr_b, 1);
    at_cyc(12); check("addr_h3", fbi.word_addr_b, 1);
    at_cyc(44); chk_rgb("rgb_e3_h10", 12'hF0F);
    at_cyc(48); chk_rgb("rgb_e3_h11", 12'hF0F);
    at_cyc(52); chk_rgb("rgb_1c_h12", 12'h0F0);
    at_cyc(60); chk_rgb("rgb_96_h14", 12'h9BA);
    at_cyc(64); chk_rgb("rgb_96_h15", 12'h9BA);
    at_cyc(68); chk_rgb("rgb_hblank", 12'h000);
    at_cyc(75); check("hs_before", vga_hs, 1);
    at_cyc(76); check("hs_first", vga_hs, 0);
    at_cyc(91); check("hs_last", vga_hs, 0);
    at_cyc(92); check("hs_after", vga_hs, 1);
    at_cyc(100); chk_rgb("rgb_ff_v1", 12'hFFF);
    at_cyc(171); check("hs2_before", vga_hs, 1);
    at_cyc(172); check("hs2_first", vga_hs, 0);
    at_cyc(192); check("addr_v2", fbi.word_addr_b, 8);
    at_cyc(732); check("addr_last", fbi.word_addr_b, 31);
    at_cyc(767); check("irq_before", frame_irq, 0);
    at_cyc(768); check("irq_pulse", frame_irq, 1);
    at_cyc(769); check("irq_after", frame_irq, 0);
    at_cyc(772); chk_rgb("rgb_vblank", 12'h000);
    at_cyc(867); check("vs_before", vga_vs, 1);
    at_cyc(868); check("vs_first", vga_vs, 0);
    at_cyc(1059); check("vs_last", vga_vs, 0);
    at_cyc(1060); check("vs_after", vga_vs, 1);
    at_cyc(1152); check("addr_wrap", fbi.word_addr_b, 0);
    at_cyc(1352); check("addr_f1_h2v2", fbi.word_addr_b, 9);
    at_cyc(1440); enable = 1'b0;
    at_cyc(1540); chk_rgb("en_persist", 12'hFFF);
    at_cyc(2308); chk_rgb("en_off_frame", 12'h000);
    at_cyc(2400); enable = 1'b1;
    at_cyc(2412); chk_rgb("en_midframe_ignored", 12'h000);
    at_cyc(3460); chk_rgb("en_restored", 12'hFFF);
    check("irq_count_3", irq_cnt, 3);
    at_cyc(3938);
    #3 res = 1'b0;
    #1;
    check("mrst_addr", fbi.word_addr_b, 0);
    chk_rgb("mrst_rgb", 12'h000);
    check("mrst_hs", vga_hs, 1);
    check("mrst_vs", vga_vs, 1);
    check("mrst_irq", frame_irq, 0);
    repeat (3) @(negedge clk);
    res = 1'b1;
    at_cyc(4);   chk_rgb("mrst_first_pix", 12'hFFF);
    at_cyc(200); check("mrst_addr_h2v2", fbi.word_addr_b, 9);
    at_cyc(700); check("mrst_no_irq", irq_cnt, 3);
    at_cyc(768); check("mrst_irq_pulse", frame_irq, 1);
    at_cyc(770); check("mrst_irq_count", irq_cnt, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
